instr_encoder_fifo: RTL and testbench

- Encoder for the 16-bit instruction decoder; performs the inverse of the decode path.
- Accepts field-level instruction requests (mode, opcode, register addresses, immediate) over a valid/ready handshake.
- Packs each request into a 16-bit instruction word and buffers it in a small FIFO.
- Presents words one per cycle to the decode stage over a second valid/ready handshake; used by the bench loader and the future fetch path.

---
 rtl/instr_encoder_fifo_if.sv | 28 ++
 rtl/instr_encoder_fifo.sv | 78 +++++++
 tb/tb_instr_encoder_fifo.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_fifo_if.sv
// Request/response bundle for the instruction encoder FIFO.
// The master drives field requests and the decode-side ready. The slave (the encoder) returns the words and status.
interface instr_encoder_fifo_if #(
  parameter int AW = 2
);
  logic        i_Valid;
  logic        o_Ready;
  logic        i_Mode;
  logic [4:0]  i_Opcode;
  logic [2:0]  i_R1;
  logic [2:0]  i_R2;
  logic [11:0] i_Imm12;
  logic [15:0] o_Instr;
  logic        o_InstrValid;
  logic        i_InstrReady;
  logic [AW:0] o_Count;
  logic        o_Err;

  modport slave (
    input  i_Valid, i_Mode, i_Opcode, i_R1, i_R2, i_Imm12, i_InstrReady,
    output o_Ready, o_Instr, o_InstrValid, o_Count, o_Err
  );

  modport master (
    output i_Valid, i_Mode, i_Opcode, i_R1, i_R2, i_Imm12, i_InstrReady,
    input  o_Ready, o_Instr, o_InstrValid, o_Count, o_Err
  );
endinterface

// File: rtl/instr_encoder_fifo.sv
// Packs field-level instruction requests into 16-bit words and queues them for the decode stage.
// Define INSTR_ENC_OPCHECK_EN to drop REG-mode requests with opcode >= 21 and pulse o_Err for them.
module instr_encoder_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                i_CLK,
  input  logic                i_RST,
  instr_encoder_fifo_if.slave bus
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          ready_q;
  logic          valid_q;
  logic          push_fire;
  logic          pop_fire;
  logic          wr_en;
  logic          illegal_op;
  logic [15:0]   packed_word;

  always_comb begin
    if (bus.i_Mode)
      packed_word = {1'b1, bus.i_R1, bus.i_Imm12};
    else
      packed_word = {1'b0, bus.i_Opcode, bus.i_R1, bus.i_R2, 4'b0000};
  end

`ifdef INSTR_ENC_OPCHECK_EN
  logic err_q;
  assign illegal_op = !bus.i_Mode && (bus.i_Opcode >= 5'd21);

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) err_q <= 1'b0;
    else       err_q <= push_fire && illegal_op;
  end
  assign bus.o_Err = err_q;
`else
  assign illegal_op = 1'b0;
  assign bus.o_Err  = 1'b0;
`endif

  // A rejected request still completes its handshake, it just never lands in the buffer.
  assign push_fire = bus.i_Valid && ready_q;
  assign wr_en     = push_fire && !illegal_op;
  assign pop_fire  = valid_q && bus.i_InstrReady;
  assign count_d   = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop_fire};

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d != FULL_CNT);
      valid_q <= (count_d != '0);
      if (wr_en)    wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_fire) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage is not reset; the pointers alone decide what is live.
  always_ff @(posedge i_CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= packed_word;
  end

  assign bus.o_Ready      = ready_q;
  assign bus.o_InstrValid = valid_q;
  assign bus.o_Count      = count_q;
  assign bus.o_Instr      = valid_q ? mem_q[rd_ptr_q] : 16'h0000;
endmodule

// File: tb/tb_instr_encoder_fifo.sv
// Bench for instr_encoder_fifo: directed scenarios plus a randomized run against a queue-based model.
// Expectations for rejected opcodes follow INSTR_ENC_OPCHECK_EN when it is defined.
module tb_instr_encoder_fifo;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_fifo_if #(.AW(AW)) ifc ();

  instr_encoder_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (ifc.slave)
  );

  int          errors = 0;
  int          checks = 0;
  logic [15:0] q[$];
  bit          exp_err;

  function automatic logic [15:0] pack(bit m, int op, int r1, int r2, int imm);
    if (m) return 16'((1 << 15) + (r1 << 12) + imm);
    return 16'((op << 10) + (r1 << 7) + (r2 << 4));
  endfunction

  function automatic bit is_illegal(bit m, int op);
`ifdef INSTR_ENC_OPCHECK_EN
    return !m && (op >= 21);
`else
    return 1'b0;
`endif
  endfunction

  // Apply one cycle of stimulus and advance the reference queue by the handshake rules.
  task automatic drive(input bit v, input bit m, input int op, input int r1, input int r2,
                       input int imm, input bit rdy);
    bit          push;
    bit          pop;
    logic [15:0] w;
    ifc.i_Valid      = v;
    ifc.i_Mode       = m;
    ifc.i_Opcode     = 5'(op);
    ifc.i_R1         = 3'(r1);
    ifc.i_R2         = 3'(r2);
    ifc.i_Imm12      = 12'(imm);
    ifc.i_InstrReady = rdy;
    push = v && (q.size() < DEPTH);
    pop  = rdy && (q.size() > 0);
    w    = pack(m, op, r1, r2, imm);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push && !is_illegal(m, op)) q.push_back(w);
    exp_err = push && is_illegal(m, op);
    $display("txn t=%0t push=%0b pop=%0b word=%04h depth=%0d", $time, push, pop, w, q.size());
    #1;
  endtask

  task automatic idle(input bit rdy);
    drive(0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ifc.i_Valid = 0; ifc.i_Mode = 0; ifc.i_Opcode = 0; ifc.i_R1 = 0; ifc.i_R2 = 0;
    ifc.i_Imm12 = 0; ifc.i_InstrReady = 0;
    q.delete();
    @(posedge clk); #1;
    checks++; if (ifc.o_Ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ifc.o_Ready); end
    checks++; if (ifc.o_Count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", ifc.o_Count); end
    checks++; if (ifc.o_InstrValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ifc.o_InstrValid); end
    checks++; if (ifc.o_Instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %04h want 0000", ifc.o_Instr); end
    rst = 1'b0;
    idle(0);
    checks++; if (ifc.o_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", ifc.o_Ready); end
  endtask

  task automatic test_reg_pack;
    drive(1, 0, 0, 3, 5, 0, 0);
    checks++; if (ifc.o_Instr !== 16'h01D0) begin errors++; $display("FAIL reg_pack_instr: got %04h want 01D0", ifc.o_Instr); end
    checks++; if (ifc.o_InstrValid !== 1'b1) begin errors++; $display("FAIL reg_pack_valid: got %b want 1", ifc.o_InstrValid); end
    checks++; if (ifc.o_Count !== 3'd1) begin errors++; $display("FAIL reg_pack_count: got %0d want 1", ifc.o_Count); end
    idle(1);
    checks++; if (ifc.o_Instr !== 16'h0000 || ifc.o_InstrValid !== 1'b0) begin
      errors++; $display("FAIL reg_pack_drain: got %04h/%b want 0000/0", ifc.o_Instr, ifc.o_InstrValid); end
  endtask

  task automatic test_order;
    drive(1, 0, 8, 2, 4, 0, 0);
    drive(1, 1, 0, 7, 0, 'hABC, 0);
    idle(0);
    checks++; if (ifc.o_Instr !== 16'h2140 || ifc.o_Count !== 3'd2) begin
      errors++; $display("FAIL order_first: got %04h cnt %0d want 2140 cnt 2", ifc.o_Instr, ifc.o_Count); end
    idle(1);
    checks++; if (ifc.o_Instr !== 16'hFABC || ifc.o_Count !== 3'd1) begin
      errors++; $display("FAIL order_second: got %04h cnt %0d want FABC cnt 1", ifc.o_Instr, ifc.o_Count); end
    idle(1);
    checks++; if (ifc.o_Count !== 3'd0) begin errors++; $display("FAIL order_empty: got %0d want 0", ifc.o_Count); end
  endtask

  task automatic test_full;
    logic [15:0] exp_w[5];
    for (int i = 0; i < 5; i++) exp_w[i] = pack(0, i + 1, i, 7 - i, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, i + 1, i, 7 - i, 0, 0);
    checks++; if (ifc.o_Ready !== 1'b0 || ifc.o_Count !== 3'd4) begin
      errors++; $display("FAIL full_state: got rdy %b cnt %0d want rdy 0 cnt 4", ifc.o_Ready, ifc.o_Count); end
    drive(1, 0, 5, 4, 3, 0, 0);
    checks++; if (ifc.o_Count !== 3'd4) begin errors++; $display("FAIL full_hold: got %0d want 4", ifc.o_Count); end
    drive(1, 0, 5, 4, 3, 0, 1);
    checks++; if (ifc.o_Ready !== 1'b1 || ifc.o_Count !== 3'd3) begin
      errors++; $display("FAIL full_pop: got rdy %b cnt %0d want rdy 1 cnt 3", ifc.o_Ready, ifc.o_Count); end
    drive(1, 0, 5, 4, 3, 0, 0);
    checks++; if (ifc.o_Count !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d want 4", ifc.o_Count); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (ifc.o_Instr !== exp_w[i]) begin
        errors++; $display("FAIL full_wrap_%0d: got %04h want %04h", i, ifc.o_Instr, exp_w[i]); end
      idle(1);
    end
  endtask

  task automatic test_simul;
    logic [15:0] w1;
    logic [15:0] w2;
    w1 = pack(0, 3, 1, 2, 0);
    w2 = pack(1, 0, 5, 0, 'h123);
    drive(1, 0, 4, 6, 6, 0, 0);
    drive(1, 0, 3, 1, 2, 0, 0);
    drive(1, 1, 0, 5, 0, 'h123, 1);
    checks++; if (ifc.o_Count !== 3'd2 || ifc.o_Instr !== w1) begin
      errors++; $display("FAIL simul_both: got cnt %0d %04h want cnt 2 %04h", ifc.o_Count, ifc.o_Instr, w1); end
    idle(1);
    checks++; if (ifc.o_Instr !== w2) begin errors++; $display("FAIL simul_order: got %04h want %04h", ifc.o_Instr, w2); end
    idle(1);
    drive(1, 0, 2, 2, 2, 0, 1);
    checks++; if (ifc.o_Count !== 3'd1) begin errors++; $display("FAIL simul_empty: got %0d want 1", ifc.o_Count); end
    idle(1);
  endtask

  task automatic test_midreset;
    for (int i = 0; i < 3; i++) drive(1, 0, 11, i, i, 0, 0);
    #3 rst = 1'b1;
    #1;
    checks++; if (ifc.o_InstrValid !== 1'b0 || ifc.o_Count !== 3'd0) begin
      errors++; $display("FAIL midreset: got vld %b cnt %0d want 0 0", ifc.o_InstrValid, ifc.o_Count); end
    q.delete();
    #10 rst = 1'b0;
    idle(0);
    drive(1, 1, 0, 3, 0, 'h5A5, 0);
    checks++; if (ifc.o_Instr !== 16'hB5A5 || ifc.o_Count !== 3'd1) begin
      errors++; $display("FAIL midreset_push: got %04h cnt %0d want B5A5 cnt 1", ifc.o_Instr, ifc.o_Count); end
    idle(1);
  endtask

  task automatic test_opcode;
    drive(1, 0, 25, 1, 2, 0, 0);
`ifdef INSTR_ENC_OPCHECK_EN
    checks++; if (ifc.o_Err !== 1'b1 || ifc.o_Count !== 3'd0) begin
      errors++; $display("FAIL opcode_reject: got err %b cnt %0d want 1 0", ifc.o_Err, ifc.o_Count); end
    idle(0);
    checks++; if (ifc.o_Err !== 1'b0) begin errors++; $display("FAIL opcode_pulse: got %b want 0", ifc.o_Err); end
`else
    checks++; if (ifc.o_Instr !== 16'h64A0 || ifc.o_Count !== 3'd1 || ifc.o_Err !== 1'b0) begin
      errors++; $display("FAIL opcode_verbatim: got %04h cnt %0d err %b want 64A0 1 0", ifc.o_Instr, ifc.o_Count, ifc.o_Err); end
`endif
    idle(1);
  endtask

  task automatic test_random;
    logic [15:0] exp_instr;
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 31),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 4095),
            1'($urandom_range(0, 2) == 0));
      exp_instr = (q.size() > 0) ? q[0] : 16'h0000;
      checks++; if (ifc.o_Count !== 3'(q.size())) begin
        errors++; $display("FAIL rand_count_%0d: got %0d want %0d", n, ifc.o_Count, q.size()); end
      checks++; if (ifc.o_Ready !== (q.size() != DEPTH) || ifc.o_InstrValid !== (q.size() != 0)) begin
        errors++; $display("FAIL rand_status_%0d: got rdy %b vld %b for depth %0d", n, ifc.o_Ready, ifc.o_InstrValid, q.size()); end
      checks++; if (ifc.o_Instr !== exp_instr) begin
        errors++; $display("FAIL rand_instr_%0d: got %04h want %04h", n, ifc.o_Instr, exp_instr); end
      checks++; if (ifc.o_Err !== exp_err) begin
        errors++; $display("FAIL rand_err_%0d: got %b want %b", n, ifc.o_Err, exp_err); end
    end
  endtask

  initial begin
    test_reset();
    test_reg_pack();
    test_order();
    test_full();
    test_simul();
    test_midreset();
    test_opcode();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
